// File: rtl/input_sync_debounce.sv
// input_sync_debounce: per-channel switch conditioner.
//   Each channel passes through an N-stage synchroniser, then a saturating
//   debounce filter that a per-cycle bypass can skip. The filtered level is
//   registered once more, so o_sw and its edge pulses change on the same edge.
// Ports:
//   i_clk      system clock, all state on posedge
//   i_reset    asynchronous active-low reset
//   i_io_sw    raw asynchronous switch levels (WIDTH)
//   i_bypass   1: stable level follows the synchroniser output directly
//   o_sw       debounced, synchronised switch levels (WIDTH)
//   o_rise     one-cycle pulse per bit on 0->1 of o_sw (WIDTH)
//   o_fall     one-cycle pulse per bit on 1->0 of o_sw (WIDTH)
//   o_changed  one-cycle pulse, OR of all rise/fall bits
module input_sync_debounce #(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_io_sw,
  input  logic             i_bypass,
  output logic [WIDTH-1:0] o_sw,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall,
  output logic             o_changed
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  s;
  logic [WIDTH-1:0]                  stable_q;
  logic [WIDTH-1:0]                  stable_d;
  logic [WIDTH-1:0][CW-1:0]          cnt_q;
  logic [WIDTH-1:0][CW-1:0]          cnt_d;

  assign s = sync_q[SYNC_STAGES-1];

  // Debounce filter: any return to the stable level restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (i_bypass) begin
        stable_d[i] = s[i];
        cnt_d[i]    = '0;
      end else if (s[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = s[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Synchroniser, filter state and output stage. o_sw lags stable_q by one
  // edge so the rise/fall pulses appear in the same cycle as the new level.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sync_q    <= '0;
      stable_q  <= '0;
      cnt_q     <= '0;
      o_sw      <= '0;
      o_rise    <= '0;
      o_fall    <= '0;
      o_changed <= 1'b0;
    end else begin
      sync_q[0] <= i_io_sw;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      o_sw      <= stable_q;
      o_rise    <= stable_q & ~o_sw;
      o_fall    <= ~stable_q & o_sw;
      o_changed <= |(stable_q ^ o_sw);
    end
  end

endmodule

// File: tb/tb_input_sync_debounce.sv
// Scoreboard bench for input_sync_debounce with default parameters.
// Stimulus pushes expected output events (edge index, level, rise, fall);
// the monitor samples 1 time unit after every rising edge, pops an event
// when it falls due and otherwise expects idle outputs at the model level.
module tb_input_sync_debounce;

  localparam int unsigned W = 32;
  localparam int LAT  = 18;  // SYNC_STAGES + DEBOUNCE_CYCLES
  localparam int BLAT = 3;   // SYNC_STAGES + 1

  typedef struct {
    int          at;
    logic [31:0] sw;
    logic [31:0] rise;
    logic [31:0] fall;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] io_sw = '1;
  logic         bypass = 1'b0;
  logic [W-1:0] sw, rise, fall;
  logic         changed;

  int          edge_cnt = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_sw = '0;
  ev_t         q[$];
  bit          done = 1'b0;

  input_sync_debounce dut (
    .i_clk    (clk),
    .i_reset  (rst_n),
    .i_io_sw  (io_sw),
    .i_bypass (bypass),
    .o_sw     (sw),
    .o_rise   (rise),
    .o_fall   (fall),
    .o_changed(changed)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Monitor: edge k after a stimulus at base is seen here with edge_cnt == base+k+1.
  always begin
    @(posedge clk);
    #1;
    if (!done) begin
      checks++;
      if (q.size() != 0 && q[0].at == edge_cnt) begin
        ev_t e;
        e = q.pop_front();
        if (sw !== e.sw || rise !== e.rise || fall !== e.fall || changed !== 1'b1) begin
          errors++;
          $display("FAIL event@%0d: got sw=%h rise=%h fall=%h chg=%b, want sw=%h rise=%h fall=%h chg=1",
                   edge_cnt, sw, rise, fall, changed, e.sw, e.rise, e.fall);
        end
        exp_sw = e.sw;
      end else begin
        if (sw !== exp_sw || rise !== '0 || fall !== '0 || changed !== 1'b0) begin
          errors++;
          $display("FAIL idle@%0d: got sw=%h rise=%h fall=%h chg=%b, want sw=%h rise=0 fall=0 chg=0",
                   edge_cnt, sw, rise, fall, changed, exp_sw);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a new input at a negedge and push the resulting event, if any.
  task automatic step(input logic [31:0] v, input logic byp, input int lat,
                      input logic [31:0] new_sw, input logic [31:0] old_sw);
    ev_t e;
    @(negedge clk);
    io_sw  = v;
    bypass = byp;
    if (new_sw != old_sw) begin
      e.at   = edge_cnt + lat + 1;
      e.sw   = new_sw;
      e.rise = new_sw & ~old_sw;
      e.fall = ~new_sw & old_sw;
      q.push_back(e);
    end
  endtask

  initial begin
    // Reset held with all inputs high: outputs must stay zero.
    cycles(6);
    io_sw = '0;
    @(negedge clk);
    rst_n = 1'b1;
    cycles(5);

    // Clean step on bit 0.
    step(32'h1, 1'b0, LAT, 32'h1, 32'h0);
    cycles(25);

    // Glitch on bit 3 lasting 10 cycles is rejected.
    step(32'h9, 1'b0, LAT, 32'h1, 32'h1);
    cycles(9);
    step(32'h1, 1'b0, LAT, 32'h1, 32'h1);
    cycles(25);

    // Return bit 0 low through the filter.
    step(32'h0, 1'b0, LAT, 32'h0, 32'h1);
    cycles(25);

    // Bypass: 0 -> A5, then A5 -> 0F.
    step(32'hA5, 1'b1, BLAT, 32'hA5, 32'h0);
    cycles(6);
    step(32'h0F, 1'b1, BLAT, 32'h0F, 32'hA5);
    cycles(6);

    // Leave bypass, then simultaneous rise and fall.
    step(32'h0F, 1'b0, LAT, 32'h0F, 32'h0F);
    cycles(3);
    step(32'hF0, 1'b0, LAT, 32'hF0, 32'h0F);
    cycles(25);
    step(32'h0, 1'b0, LAT, 32'h0, 32'hF0);
    cycles(25);

    // Bit 7 rises, reset pulses mid-count, full latency restarts on release.
    step(32'h80, 1'b0, LAT, 32'h0, 32'h0);
    cycles(7);
    rst_n = 1'b0;
    exp_sw = '0;
    cycles(2);
    step(32'h80, 1'b0, LAT, 32'h80, 32'h0);
    rst_n = 1'b1;
    cycles(25);

    done = 1'b1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending: got %0d unconsumed events, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
